// File: rtl/pellet_eater.sv
// Maze tile RAM port-A owner: copies the level maze from ROM, then clears eaten
// food/power tiles with a read-modify-write and keeps a saturating score.
module pellet_eater #(
    parameter int          NUM_TILES = 768,
    parameter logic [3:0]  FOOD      = 4'd2,
    parameter logic [3:0]  POWER     = 4'd3,
    parameter logic [3:0]  EMPTY     = 4'd0,
    parameter logic [15:0] FOOD_PTS  = 16'd10,
    parameter logic [15:0] POWER_PTS = 16'd50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_start,
    output logic [9:0]  rom_addr,
    input  logic [3:0]  rom_data,
    input  logic        eat_req,
    input  logic [4:0]  eat_x,
    input  logic [4:0]  eat_y,
    output logic        eat_ack,
    output logic        ate_food,
    output logic        ate_power,
    output logic [9:0]  ram_addr,
    input  logic [3:0]  ram_rd_data,
    output logic [3:0]  ram_wr_data,
    output logic        ram_wr_en,
    output logic        busy,
    output logic [15:0] score
);

    typedef enum logic [1:0] {IDLE, INIT, RD, CHK} state_t;

    localparam logic [9:0] LAST = 10'(NUM_TILES);
    localparam logic [5:0] ROWS = 6'(NUM_TILES / 32);

    state_t      state_q, state_d;
    logic [9:0]  i_q, i_d;
    logic [9:0]  addr_q, addr_d;
    logic        inrange_q, inrange_d;
    logic [15:0] score_q, score_d;
    logic        hit_food, hit_power;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Off-maze rows still complete the handshake but never touch RAM or score.
    assign hit_food  = inrange_q && (ram_rd_data == FOOD);
    assign hit_power = inrange_q && (ram_rd_data == POWER);

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        addr_d      = addr_q;
        inrange_d   = inrange_q;
        score_d     = score_q;
        rom_addr    = '0;
        ram_addr    = '0;
        ram_wr_data = '0;
        ram_wr_en   = 1'b0;
        eat_ack     = 1'b0;
        ate_food    = 1'b0;
        ate_power   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (init_start) begin
                    state_d = INIT;
                    i_d     = '0;
                    score_d = '0;
                end else if (eat_req) begin
                    state_d   = RD;
                    addr_d    = {eat_y, eat_x};
                    inrange_d = ({1'b0, eat_y} < ROWS);
                end
            end
            INIT: begin
                // ROM data lags its address by one cycle, so write tile i-1 while fetching i.
                if (i_q < LAST) rom_addr = i_q;
                if (i_q != 10'd0) begin
                    ram_wr_en   = 1'b1;
                    ram_addr    = i_q - 10'd1;
                    ram_wr_data = rom_data;
                end
                if (i_q == LAST) begin
                    state_d = IDLE;
                    i_d     = '0;
                end else begin
                    i_d = i_q + 10'd1;
                end
            end
            RD: begin
                ram_addr = addr_q;
                state_d  = CHK;
            end
            CHK: begin
                ram_addr  = addr_q;
                eat_ack   = 1'b1;
                ate_food  = hit_food;
                ate_power = hit_power;
                if (hit_food || hit_power) begin
                    ram_wr_en   = 1'b1;
                    ram_wr_data = EMPTY;
                    score_d     = sat_add(score_q, hit_power ? POWER_PTS : FOOD_PTS);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            i_q       <= '0;
            addr_q    <= '0;
            inrange_q <= 1'b0;
            score_q   <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            addr_q    <= addr_d;
            inrange_q <= inrange_d;
            score_q   <= score_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign score = score_q;

endmodule

// File: tb/tb_pellet_eater.sv
// Directed bench for pellet_eater with behavioural maze ROM and tile RAM models.
module tb_pellet_eater;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init_start = 1'b0;
    logic [9:0]  rom_addr;
    logic [3:0]  rom_data = 4'd0;
    logic        eat_req = 1'b0;
    logic [4:0]  eat_x = 5'd0;
    logic [4:0]  eat_y = 5'd0;
    logic        eat_ack, ate_food, ate_power;
    logic [9:0]  ram_addr;
    logic [3:0]  ram_rd_data = 4'd0;
    logic [3:0]  ram_wr_data;
    logic        ram_wr_en;
    logic        busy;
    logic [15:0] score;

    logic [3:0]  rom [1024];
    logic [3:0]  mem [1024];
    logic        poke_en = 1'b0;
    logic [9:0]  poke_addr = 10'd0;
    logic [3:0]  poke_val = 4'd0;

    int checks = 0;
    int failures = 0;

    pellet_eater dut (
        .clk(clk), .reset(reset), .init_start(init_start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .eat_req(eat_req), .eat_x(eat_x), .eat_y(eat_y),
        .eat_ack(eat_ack), .ate_food(ate_food), .ate_power(ate_power),
        .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
        .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
        .busy(busy), .score(score)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_val;
        else if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_addr];
    end

    typedef struct {
        logic [4:0] x;
        logic [4:0] y;
        bit         pre_en;
        logic [3:0] pre_val;
        bit         e_food;
        bit         e_power;
        logic [3:0] e_tile;
        int         e_score;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [3:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_val = v;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Waits for eat_ack with eat_req already high and the DUT idle; lat counts edges.
    task automatic wait_ack(output int lat, output bit f, output bit p, output bit wr);
        lat = 0;
        while (!eat_ack && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        f = ate_food; p = ate_power; wr = ram_wr_en;
        eat_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_eat(input logic [4:0] x, input logic [4:0] y,
                          output int lat, output bit f, output bit p, output bit wr);
        @(negedge clk);
        eat_x = x; eat_y = y; eat_req = 1'b1;
        wait_ack(lat, f, p, wr);
    endtask

    task automatic run_init(input bit with_eat, output int busy_cnt, output int wr_cnt);
        @(negedge clk);
        init_start = 1'b1;
        if (with_eat) eat_req = 1'b1;
        @(posedge clk); #1;
        init_start = 1'b0;
        busy_cnt = 0; wr_cnt = 0;
        while (busy && busy_cnt < 3000) begin
            busy_cnt++;
            if (ram_wr_en) wr_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_wr_en"}, int'(ram_wr_en), 0);
        check({tag, "_ack"}, int'(eat_ack), 0);
        check({tag, "_flags"}, int'({ate_food, ate_power}), 0);
        check({tag, "_rom_addr"}, int'(rom_addr), 0);
        check({tag, "_ram_addr"}, int'(ram_addr), 0);
        check({tag, "_wr_data"}, int'(ram_wr_data), 0);
        check({tag, "_score"}, int'(score), 0);
    endtask

    initial begin
        int  bc, wc, lat;
        bit  f, p, wr;
        logic [9:0] a;

        for (int k = 0; k < 1024; k++) rom[k] = 4'(k % 4);
        rom[101] = 4'd2;

        vecs[0] = '{5'd5,  5'd3,  1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 10};
        vecs[1] = '{5'd5,  5'd3,  1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 10};
        vecs[2] = '{5'd31, 5'd23, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 60};
        vecs[3] = '{5'd0,  5'd0,  1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 60};
        vecs[4] = '{5'd1,  5'd0,  1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 60};
        vecs[5] = '{5'd2,  5'd0,  1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 70};
        vecs[6] = '{5'd3,  5'd0,  1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 120};
        vecs[7] = '{5'd31, 5'd24, 1'b1, 4'd2, 1'b0, 1'b0, 4'd2, 120};
        vecs[8] = '{5'd0,  5'd25, 1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 120};

        #2 reset = 1'b1;
        #1 check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        run_init(1'b0, bc, wc);
        check("init_busy_cycles", bc, 769);
        check("init_wr_cycles", wc, 768);
        check("init_tile0", int'(mem[0]), int'(rom[0]));
        check("init_tile101", int'(mem[101]), 2);
        check("init_tile383", int'(mem[383]), int'(rom[383]));
        check("init_tile767", int'(mem[767]), int'(rom[767]));
        check("init_score", int'(score), 0);

        for (int n = 0; n < 9; n++) begin
            a = {vecs[n].y, vecs[n].x};
            if (vecs[n].pre_en) poke(a, vecs[n].pre_val);
            do_eat(vecs[n].x, vecs[n].y, lat, f, p, wr);
            check($sformatf("vec%0d_latency", n), lat, 2);
            check($sformatf("vec%0d_ate_food", n), int'(f), int'(vecs[n].e_food));
            check($sformatf("vec%0d_ate_power", n), int'(p), int'(vecs[n].e_power));
            check($sformatf("vec%0d_wr_en", n), int'(wr), int'(vecs[n].e_food | vecs[n].e_power));
            check($sformatf("vec%0d_tile", n), int'(mem[a]), int'(vecs[n].e_tile));
            check($sformatf("vec%0d_score", n), int'(score), vecs[n].e_score);
        end

        // 1308 power pellets take the score from 120 to exactly 0xFFF0.
        for (int n = 0; n < 1308; n++) begin
            poke(10'd3, 4'd3);
            do_eat(5'd3, 5'd0, lat, f, p, wr);
        end
        check("sat_pre_score", int'(score), 32'hFFF0);
        poke(10'd3, 4'd3);
        do_eat(5'd3, 5'd0, lat, f, p, wr);
        check("sat_power_flag", int'(p), 1);
        check("sat_power_score", int'(score), 32'hFFFF);
        poke(10'd2, 4'd2);
        do_eat(5'd2, 5'd0, lat, f, p, wr);
        check("sat_food_flag", int'(f), 1);
        check("sat_food_score", int'(score), 32'hFFFF);

        eat_x = 5'd5; eat_y = 5'd3;
        run_init(1'b1, bc, wc);
        check("both_busy_cycles", bc, 769);
        check("both_wr_cycles", wc, 768);
        check("both_score_cleared", int'(score), 0);
        wait_ack(lat, f, p, wr);
        check("both_eat_latency", lat, 2);
        check("both_eat_food", int'(f), 1);
        check("both_eat_tile", int'(mem[101]), 0);
        check("both_eat_score", int'(score), 10);

        poke(10'd807, 4'd2);
        do_eat(5'd7, 5'd25, lat, f, p, wr);
        check("oor_latency", lat, 2);
        check("oor_flags", int'({f, p}), 0);
        check("oor_wr_en", int'(wr), 0);
        check("oor_tile", int'(mem[807]), 2);
        check("oor_score", int'(score), 10);

        poke(10'd383, 4'hF);
        poke(10'd767, 4'hF);
        @(negedge clk) init_start = 1'b1;
        @(posedge clk); #1;
        init_start = 1'b0;
        repeat (299) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        #1 check_reset_outputs("rst_mid");
        check("rst_mid_partial", int'(mem[383]), 15);
        @(negedge clk) reset = 1'b0;
        run_init(1'b0, bc, wc);
        check("reinit_busy_cycles", bc, 769);
        check("reinit_wr_cycles", wc, 768);
        check("reinit_tile0", int'(mem[0]), 0);
        check("reinit_tile101", int'(mem[101]), 2);
        check("reinit_tile383", int'(mem[383]), 3);
        check("reinit_tile767", int'(mem[767]), 3);
        check("reinit_score", int'(score), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
